// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: reset defaults, FSM encoding and F/D payload.
// Used by fetch_stage and fd_reg.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] IMEM_WINDOW   = 32'h0000_4000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } fd_t;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// Generic pipeline register with enable, clear and synchronous reset.
// On clear, bits selected by CLR_KEEP pass through from d; the rest load CLR_VAL.
module fd_reg #(
    parameter int           W        = 1,
    parameter logic [W-1:0] RST_VAL  = '0,
    parameter logic [W-1:0] CLR_VAL  = '0,
    parameter logic [W-1:0] CLR_KEEP = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= clr ? ((d & CLR_KEEP) | CLR_VAL) : d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// F-stage PC register, F/D pipeline register, BOOT/RUN FSM and performance counters.
// Optional macro FETCH_ADEL_CHECK_EN adds instruction address-error detection.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      F_nextPC,
    input  logic             stall,
    input  logic             D_flush,
    input  logic [31:0]      i_inst_rdata,
    output logic [31:0]      i_inst_addr,
    output logic [31:0]      F_PC,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_instr,
    output logic             D_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fetch_cnt,
`ifdef FETCH_ADEL_CHECK_EN
    output logic             F_excAdEL,
    output logic             D_excAdEL,
    output logic             boot_first,
`endif
    output state_t           fsm_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam fd_t FD_RST  = '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    localparam fd_t FD_CLR  = '{pc: 32'h0,    instr: NOP_INSTR, valid: 1'b0};
    // A flushed bubble still records the PC it replaced.
    localparam fd_t FD_KEEP = '{pc: 32'hFFFF_FFFF, instr: 32'h0, valid: 1'b0};

    fd_t         fd_d;
    fd_t         fd_q;
    logic [31:0] fetch_word;

    assign i_inst_addr = F_PC;

`ifdef FETCH_ADEL_CHECK_EN
    logic [31:0] pc_offset;
    assign pc_offset  = F_PC - RESET_PC;
    // Unsigned offset catches both below-window and above-window addresses.
    assign F_excAdEL  = (F_PC[1:0] != 2'b00) || (pc_offset >= IMEM_WINDOW);
    assign fetch_word = F_excAdEL ? NOP_INSTR : i_inst_rdata;

    fd_reg #(
        .W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0), .CLR_KEEP(1'b0)
    ) u_fd_exc (
        .clk   (clk),
        .reset (reset),
        .en    (~stall),
        .clr   (D_flush),
        .d     (F_excAdEL),
        .q     (D_excAdEL)
    );
`else
    assign fetch_word = i_inst_rdata;
`endif

    assign fd_d = '{pc: F_PC, instr: fetch_word, valid: 1'b1};

    fd_reg #(
        .W        ($bits(fd_t)),
        .RST_VAL  (FD_RST),
        .CLR_VAL  (FD_CLR),
        .CLR_KEEP (FD_KEEP)
    ) u_fd (
        .clk   (clk),
        .reset (reset),
        .en    (~stall),
        .clr   (D_flush),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign D_PC    = fd_q.pc;
    assign D_instr = fd_q.instr;
    assign D_valid = fd_q.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC      <= RESET_PC;
            fsm_state <= BOOT;
            stall_cnt <= '0;
            fetch_cnt <= '0;
`ifdef FETCH_ADEL_CHECK_EN
            boot_first <= 1'b0;
`endif
        end else begin
            fsm_state <= RUN;
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                F_PC <= F_nextPC;
                if (!D_flush) begin
                    fetch_cnt <= fetch_cnt + CNT_ONE;
                end
`ifdef FETCH_ADEL_CHECK_EN
                // Marks the instruction fetched on the single BOOT cycle.
                boot_first <= (fsm_state == BOOT) && !D_flush;
`endif
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage PC register plus F/D pipeline register for the 5-stage MIPS core.
- Holds F_PC and drives the instruction-memory address.
- Latches F_nextPC from the next-PC logic each cycle. Freezes on hazard stall; clears D on flush.
- Presents D_PC/D_instr/D_valid to the decode stage and F_PC back to next-PC logic (which computes D_PC as F_PC-4).

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into D on reset/flush.
- CNT_W, 32, width of stall and fetch performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- F_nextPC  input  32  next PC from next-PC logic
- stall  input  1  hazard unit: freeze PC and F/D register
- D_flush  input  1  load bubble into F/D register (PC still advances unless stalled)
- i_inst_rdata  input  32  instruction word at i_inst_addr (combinational memory)
- i_inst_addr  output  32  equals F_PC
- F_PC  output  32  current fetch PC
- D_PC  output  32  PC of instruction in D
- D_instr  output  32  instruction in D
- D_valid  output  1  D holds a real instruction
- stall_cnt  output  CNT_W  cycles with stall=1 since reset
- fetch_cnt  output  CNT_W  instructions moved into D since reset

Behaviour:
- Reset (synchronous, active-high; sampled at posedge clk):
  - F_PC=RESET_PC, D_PC=RESET_PC, D_instr=NOP_INSTR, D_valid=0.
  - stall_cnt=0, fetch_cnt=0.
  - Reset has priority over stall and D_flush.
  - Reset mid-operation discards all state in the same edge.
- i_inst_addr = F_PC, combinational.
- Per clock edge, priority order after reset:
  - stall=1: F_PC, D_PC, D_instr, D_valid all hold, even if D_flush=1 (the flush is ignored). stall_cnt increments.
  - stall=0, D_flush=1: F_PC<=F_nextPC; D_instr<=NOP_INSTR; D_valid<=0; D_PC<=F_PC.
  - stall=0, D_flush=0: F_PC<=F_nextPC; D_PC<=F_PC; D_instr<=i_inst_rdata; D_valid<=1; fetch_cnt increments.
- Latency: one cycle from F_PC to D_PC/D_instr. Delay slot is naturally fetched because F_PC advances every non-stalled cycle.
- F_nextPC is taken verbatim; no alignment correction here.
- Counters wrap at 2^CNT_W-1 -> 0 with no saturation and no flag.
- Internal FSM, two states:
  - BOOT: entered on reset. Lasts exactly one cycle after reset deasserts.
  - RUN: BOOT->RUN on the first clock with reset=0, regardless of stall. In BOOT, stall is honoured as normal.
  - RUN->BOOT only on reset.
  - boot_first (internal) marks the first fetched instruction. It is exposed only under the optional feature.

Optional Feature:
- Macro FETCH_ADEL_CHECK_EN.
- Defined:
  - Adds output F_excAdEL (1 bit), combinational: high when F_PC[1:0]!=0 or F_PC is outside [RESET_PC, RESET_PC+32'h3FFF].
  - Adds registered D_excAdEL, which travels with D_instr under the same stall/flush/reset rules (reset/flush -> 0).
  - When F_excAdEL=1 and the instruction is not stalled, D_instr<=NOP_INSTR instead of i_inst_rdata, D_valid<=1, and fetch_cnt still increments.
- Undefined: no extra ports; no address checking.

Decomposition:
- Shared package/include holds:
  - RESET_PC and NOP_INSTR defaults.
  - BOOT/RUN state encodings.
  - Instruction-memory window size 32'h4000.
- One sub-module, fd_reg: the F/D pipeline register with en/clr/reset, reused later for D/E, E/M and M/W.
- The PC register, FSM and counters stay in fetch_stage.

Test Plan:
- Reset for 2 cycles, then release with F_nextPC=F_PC+4 -> after reset F_PC=0x3000, D_valid=0. Next edge: F_PC=0x3004, D_PC=0x3000, D_instr=word@0x3000, D_valid=1, fetch_cnt=1.
- stall=1 for 3 cycles at F_PC=0x3008 -> F_PC, D_PC, D_instr unchanged. stall_cnt=3, fetch_cnt unchanged. Release -> F_PC=0x300C.
- Jump: D holds jal, F_nextPC=0x3100 -> next edge F_PC=0x3100 and D_PC=0x3004 (delay slot). The edge after: D_PC=0x3100.
- D_flush=1, stall=0 at F_PC=0x3010 -> F_PC=F_nextPC, D_instr=0, D_valid=0, D_PC=0x3010. With stall=1 and D_flush=1 at the same time -> all hold.
- reset=1 while stall=1 at F_PC=0x3020 -> next edge F_PC=0x3000, counters=0, D_valid=0.
- With FETCH_ADEL_CHECK_EN: F_nextPC=0x3002 -> F_excAdEL=1. Next edge D_excAdEL=1, D_instr=0, D_valid=1. F_nextPC=0x7000 -> out-of-window flag.
